// File: rtl/spi_frame_master_if.sv
// Host-side request/response bundle for spi_frame_master.
// The master modport is the requester; the slave modport is the frame engine.
interface spi_frame_master_if;
    localparam int unsigned WORD_W = 10;
    localparam int unsigned DATA_W = 8;

    logic              start;
    logic [WORD_W-1:0] tx_word;
    logic              ready;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;

    modport master (
        output start, tx_word,
        input  ready, busy, rd_data, rd_valid, done
    );

    modport slave (
        input  start, tx_word,
        output ready, busy, rd_data, rd_valid, done
    );
endinterface

// File: rtl/spi_frame_master.sv
// SPI master issuing 10-bit {cmd, payload} frames, one bit per clk,
// capturing an 8-bit reply for read-data (cmd=11) frames.
module spi_frame_master #(
    parameter int unsigned RD_TURNAROUND = 3,
    parameter int unsigned IDLE_GAP      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_frame_master_if.slave        host,
    output logic                     SS_n,
    output logic                     MOSI,
    input  logic                     MISO
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(RD_TURNAROUND - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, WAKE, CMD, SHIFT, HOLD, TURN, CAPTURE, GAP
    } state_t;

    state_t           state;
    logic [9:0]       word_q;
    logic [1:0]       cmd_q;
    logic [7:0]       shift_q;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             busy_q;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic             done_q;

    assign host.ready    = ready_q;
    assign host.busy     = busy_q;
    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;
    assign host.done     = done_q;

    // Outputs are registered alongside the state they belong to, so each
    // transition also loads the pin values for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_q     <= '0;
            cmd_q      <= '0;
            shift_q    <= '0;
            cnt        <= '0;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.start) begin
                        word_q  <= host.tx_word;
                        cmd_q   <= host.tx_word[9:8];
                        state   <= WAKE;
                        SS_n    <= 1'b0;
                        MOSI    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                WAKE: begin
                    state <= CMD;
                    MOSI  <= word_q[9];
                end
                CMD: begin
                    state <= SHIFT;
                    MOSI  <= word_q[9];
                    cnt   <= '0;
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        MOSI <= 1'b0;
                        cnt  <= '0;
                        if (cmd_q == 2'b11) begin
                            state <= (RD_TURNAROUND == 0) ? CAPTURE : TURN;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        MOSI   <= word_q[8];
                        word_q <= {word_q[8:0], 1'b0};
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    state  <= GAP;
                    SS_n   <= 1'b1;
                    done_q <= 1'b1;
                    cnt    <= '0;
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    shift_q <= {shift_q[6:0], MISO};
                    if (cnt == CAP_LAST) begin
                        state      <= GAP;
                        SS_n       <= 1'b1;
                        done_q     <= 1'b1;
                        rd_data_q  <= {shift_q[6:0], MISO};
                        rd_valid_q <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: frames are queued with hand-computed
// expectations and a monitor checks each one when its done pulse appears.
module tb_spi_frame_master;
    logic clk = 1'b0;
    logic rst;
    logic ss_n, mosi, miso;
    logic ss_n0, mosi0, miso0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    spi_frame_master_if hif ();
    spi_frame_master_if hif0 ();

    spi_frame_master #(.RD_TURNAROUND(3), .IDLE_GAP(1)) dut (
        .clk(clk), .rst(rst), .host(hif), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_frame_master #(.RD_TURNAROUND(0), .IDLE_GAP(1)) dut0 (
        .clk(clk), .rst(rst), .host(hif0), .SS_n(ss_n0), .MOSI(mosi0), .MISO(miso0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] bits;    // MOSI in T+2..T+12, first bit at MSB
        int          ss_low;
        int          lat;
        logic        rdv;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q0[$];

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) cycle=%0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: actual=event required=no_event cycle=%0d", nm, cyc);
    endtask

    task automatic expect_frame(input logic [10:0] b, input int ss, input int lat,
                                input logic rdv, input logic [7:0] d);
        exp_t e;
        e.bits = b; e.ss_low = ss; e.lat = lat; e.rdv = rdv; e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!hif.ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) fail("ready_timeout");
    endtask

    // Returns at cycle T+1 (just after the accept edge).
    task automatic accept(input logic [9:0] w);
        wait_ready();
        hif.start   = 1'b1;
        hif.tx_word = w;
        @(posedge clk); #1;
        hif.start   = 1'b0;
        hif.tx_word = 10'h155;
    endtask

    // Called at T+1; drives byte b MSB first starting at cycle T+1+wait_n.
    task automatic drive_miso(input logic [7:0] b, input int wait_n, input logic sel0);
        repeat (wait_n) @(posedge clk);
        #1;
        for (int i = 7; i >= 0; i--) begin
            if (sel0) miso0 = b[i]; else miso = b[i];
            @(posedge clk); #1;
        end
        miso  = 1'b1;
        miso0 = 1'b1;
    endtask

    // Monitor for the R=3 instance.
    int          ss_cnt = 0;
    int          acc_cyc = 0;
    logic [10:0] mosi_acc = '0;
    logic        mosi_extra = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ss_cnt = 0; mosi_acc = '0; mosi_extra = 1'b0;
        end else begin
            if (hif.ready && hif.start) acc_cyc = cyc;
            if (!ss_n) begin
                ss_cnt++;
                if (ss_cnt >= 2 && ss_cnt <= 12) mosi_acc = {mosi_acc[9:0], mosi};
                else if (mosi) mosi_extra = 1'b1;
            end
            if (hif.rd_valid && !hif.done) fail("rd_valid_without_done");
            if (hif.done) begin
                if (sb.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    check("mosi_stream", int'(mosi_acc), int'(e.bits));
                    check("mosi_idle_bits", int'(mosi_extra), 0);
                    check("ss_low_cycles", ss_cnt, e.ss_low);
                    check("done_latency", cyc - acc_cyc, e.lat);
                    check("done_ss_n", int'(ss_n), 1);
                    check("rd_valid", int'(hif.rd_valid), int'(e.rdv));
                    check("rd_data", int'(hif.rd_data), int'(e.data));
                end
                ss_cnt = 0; mosi_acc = '0; mosi_extra = 1'b0;
            end
        end
    end

    // Monitor for the R=0 instance.
    int acc0 = 0;
    always @(negedge clk) begin
        logic [7:0] d;
        if (!rst) begin
            if (hif0.ready && hif0.start) acc0 = cyc;
            if (hif0.done) begin
                if (q0.size() == 0) begin
                    fail("r0_unexpected_done");
                end else begin
                    d = q0.pop_front();
                    check("r0_latency", cyc - acc0, 21);
                    check("r0_rd_valid", int'(hif0.rd_valid), 1);
                    check("r0_rd_data", int'(hif0.rd_data), int'(d));
                    check("r0_ss_n", int'(ss_n0), 1);
                    check("r0_mosi", int'(mosi0), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        hif.start = 1'b0;  hif.tx_word = '0;  miso = 1'b1;
        hif0.start = 1'b0; hif0.tx_word = '0; miso0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ss_n", int'(ss_n), 1);
        check("rst_mosi", int'(mosi), 0);
        check("rst_ready", int'(hif.ready), 1);
        check("rst_busy", int'(hif.busy), 0);
        check("rst_rd_data", int'(hif.rd_data), 0);
        check("rst_rd_valid", int'(hif.rd_valid), 0);
        check("rst_done", int'(hif.done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write-address.
        expect_frame(11'b0_00_1010_0101, 13, 14, 1'b0, 8'h00);
        accept(10'b00_1010_0101);
        check("busy_after_accept", int'(hif.busy), 1);
        check("ready_after_accept", int'(hif.ready), 0);

        // Write-data with a start pulse at T+5 that must be ignored.
        expect_frame(11'b0_01_0011_1100, 13, 14, 1'b0, 8'h00);
        accept(10'b01_0011_1100);
        repeat (4) @(posedge clk);
        #1;
        hif.start = 1'b1; hif.tx_word = 10'h3FF;
        @(posedge clk); #1;
        hif.start = 1'b0;

        // Read-data, R=3, slave returns 0xC3 in T+16..T+23.
        expect_frame(11'b1_11_0000_0000, 23, 24, 1'b1, 8'hC3);
        accept(10'b11_0000_0000);
        drive_miso(8'hC3, 15, 1'b0);

        // Read-address: rd_data must hold 0xC3.
        expect_frame(11'b1_10_1111_0000, 13, 14, 1'b0, 8'hC3);
        accept(10'b10_1111_0000);

        // Back-to-back write frames with start held high.
        expect_frame(11'b0_01_1111_1111, 13, 14, 1'b0, 8'hC3);
        expect_frame(11'b0_00_0000_0001, 13, 14, 1'b0, 8'hC3);
        wait_ready();
        hif.start = 1'b1; hif.tx_word = 10'b01_1111_1111;
        @(posedge clk); #1;
        hif.tx_word = 10'b00_0000_0001;
        repeat (13) @(posedge clk);
        #1;
        check("b2b_gap_ss_n", int'(ss_n), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_wake_ss_n", int'(ss_n), 0);
        check("b2b_wake_busy", int'(hif.busy), 1);
        hif.start = 1'b0;

        // Reset in the middle of SHIFT: no done, rd_data cleared.
        accept(10'b00_1010_0101);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ss_n", int'(ss_n), 1);
        check("midrst_mosi", int'(mosi), 0);
        check("midrst_rd_data", int'(hif.rd_data), 0);
        check("midrst_ready", int'(hif.ready), 1);
        check("midrst_done", int'(hif.done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_ss_n", int'(ss_n), 1);

        // Turnaround 0 instance: 0x5A in T+13..T+20.
        q0.push_back(8'h5A);
        hif0.start = 1'b1; hif0.tx_word = 10'b11_0000_0000;
        @(posedge clk); #1;
        hif0.start = 1'b0;
        drive_miso(8'h5A, 12, 1'b1);

        repeat (30) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("q0_drained", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
